// File: rtl/scanner_pkg.sv
// rtl/scanner_pkg.sv - shared state encoding and sweep-mode constants for region_scanner
package scanner_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic MODE_RASTER = 1'b0;
    localparam logic MODE_SERP   = 1'b1;

endpackage

// File: rtl/region_scanner_if.sv
// rtl/region_scanner_if.sv - control and coordinate-stream bundle between scanner and its users
interface region_scanner_if #(
    parameter int X_WIDTH   = 8,
    parameter int Y_WIDTH   = 7,
    parameter int IDX_WIDTH = 15
);
    logic                 start;
    logic                 abort;
    logic                 serpentine;
    logic [X_WIDTH-1:0]   x0;
    logic [X_WIDTH-1:0]   x1;
    logic [Y_WIDTH-1:0]   y0;
    logic [Y_WIDTH-1:0]   y1;
    logic                 out_valid;
    logic                 out_ready;
    logic [X_WIDTH-1:0]   x;
    logic [Y_WIDTH-1:0]   y;
    logic [IDX_WIDTH-1:0] index;
    logic                 last;
    logic                 busy;
    logic                 done;
    logic                 bad_region;

    // Scanner side: takes commands and bounds, produces the coordinate stream.
    modport master (
        input  start, abort, serpentine, x0, x1, y0, y1, out_ready,
        output out_valid, x, y, index, last, busy, done, bad_region
    );

    // Control/consumer side.
    modport slave (
        output start, abort, serpentine, x0, x1, y0, y1, out_ready,
        input  out_valid, x, y, index, last, busy, done, bad_region
    );
endinterface

// File: rtl/axis_stepper.sv
// rtl/axis_stepper.sv - loadable up/down coordinate counter with end-of-axis flag
module axis_stepper #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             step_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] end_val_i,
    output logic [WIDTH-1:0] value_o,
    output logic             at_end_o
);
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Load wins over step; the caller never steps past end_val, so no wrap.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (step_i) begin
            value_d = down_i ? (value_q - WIDTH'(1)) : (value_q + WIDTH'(1));
        end
    end

    // Coordinate register.
    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o  = value_q;
    assign at_end_o = (value_q == end_val_i);
endmodule

// File: rtl/region_scanner.sv
// rtl/region_scanner.sv - rectangle sweeper emitting (x,y,index) over a valid/ready stream
module region_scanner
    import scanner_pkg::*;
#(
    parameter int X_WIDTH   = 8,
    parameter int Y_WIDTH   = 7,
    parameter int IDX_WIDTH = 15
) (
    input  logic             clock,
    input  logic             reset,
    region_scanner_if.master bus
);
    state_t               state_q;
    state_t               state_d;
    logic [X_WIDTH-1:0]   x0_q;
    logic [X_WIDTH-1:0]   x1_q;
    logic [Y_WIDTH-1:0]   y0_q;
    logic [Y_WIDTH-1:0]   y1_q;
    logic                 serp_q;
    logic [IDX_WIDTH-1:0] index_q;
    logic [IDX_WIDTH-1:0] index_d;
    logic                 bad_q;
    logic                 bad_d;

    logic                 legal;
    logic                 start_ok;
    logic                 run;
    logic                 hs;
    logic [X_WIDTH-1:0]   x_val;
    logic [Y_WIDTH-1:0]   y_val;
    logic                 x_at_end;
    logic                 y_at_end;
    logic                 row_odd;
    logic [X_WIDTH-1:0]   row_end_x;
    logic                 last_c;
    logic                 x_load;
    logic [X_WIDTH-1:0]   x_load_val;
    logic                 x_step;
    logic                 y_step;

    assign legal    = (bus.x1 >= bus.x0) && (bus.y1 >= bus.y0);
    assign start_ok = (state_q == S_IDLE) && bus.start && legal;
    assign run      = (state_q == S_RUN);
    // Abort overrides a same-cycle handshake.
    assign hs       = run && bus.out_ready && !bus.abort;

    // Parity of (y - y0) is just the xor of the two LSBs.
    assign row_odd   = (serp_q == MODE_SERP) && (y_val[0] ^ y0_q[0]);
    assign row_end_x = row_odd ? x0_q : x1_q;
    assign last_c    = run && x_at_end && y_at_end;

    // Raster wraps x back to x0 at row end; serpentine holds x and turns around.
    assign x_load     = start_ok || (hs && x_at_end && !y_at_end && (serp_q == MODE_RASTER));
    assign x_load_val = start_ok ? bus.x0 : x0_q;
    assign x_step     = hs && !x_at_end;
    assign y_step     = hs && x_at_end && !y_at_end;

    axis_stepper #(.WIDTH(X_WIDTH)) u_x_axis (
        .clock      (clock),
        .reset      (reset),
        .load_i     (x_load),
        .load_val_i (x_load_val),
        .step_i     (x_step),
        .down_i     (row_odd),
        .end_val_i  (row_end_x),
        .value_o    (x_val),
        .at_end_o   (x_at_end)
    );

    axis_stepper #(.WIDTH(Y_WIDTH)) u_y_axis (
        .clock      (clock),
        .reset      (reset),
        .load_i     (start_ok),
        .load_val_i (bus.y0),
        .step_i     (y_step),
        .down_i     (1'b0),
        .end_val_i  (y1_q),
        .value_o    (y_val),
        .at_end_o   (y_at_end)
    );

    // Next state, index counter and bad-region pulse.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        bad_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (legal) begin
                        state_d = S_RUN;
                        index_d = '0;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (hs) begin
                    if (last_c) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + IDX_WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, index and pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            index_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            bad_q   <= bad_d;
        end
    end

    // Bounds and mode are captured only when a legal start is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            x0_q   <= '0;
            x1_q   <= '0;
            y0_q   <= '0;
            y1_q   <= '0;
            serp_q <= MODE_RASTER;
        end else if (start_ok) begin
            x0_q   <= bus.x0;
            x1_q   <= bus.x1;
            y0_q   <= bus.y0;
            y1_q   <= bus.y1;
            serp_q <= bus.serpentine;
        end
    end

    assign bus.out_valid  = run;
    assign bus.busy       = run;
    assign bus.done       = (state_q == S_DONE);
    assign bus.bad_region = bad_q;
    assign bus.x          = x_val;
    assign bus.y          = y_val;
    assign bus.index      = index_q;
    assign bus.last       = last_c;
endmodule

// File: tb/tb_region_scanner.sv
// tb/tb_region_scanner.sv - self-checking bench for region_scanner
module tb_region_scanner;

    typedef struct {
        int x;
        int y;
        int idx;
        int last;
    } exp_t;

    typedef struct {
        int x0;
        int x1;
        int y0;
        int y1;
        int serp;
        int mode;
        int exp_hs;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    exp_t exp_q[$];

    region_scanner_if #(.X_WIDTH(8), .Y_WIDTH(7), .IDX_WIDTH(15)) bus ();

    region_scanner #(.X_WIDTH(8), .Y_WIDTH(7), .IDX_WIDTH(15)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    task automatic build_expect(input int a0, input int a1, input int b0, input int b1, input int serp);
        int idx;
        exp_t e;
        idx = 0;
        for (int yy = b0; yy <= b1; yy++) begin
            for (int k = 0; k <= a1 - a0; k++) begin
                e.x    = (serp != 0 && ((yy - b0) % 2) == 1) ? (a1 - k) : (a0 + k);
                e.y    = yy;
                e.idx  = idx;
                e.last = (yy == b1 && k == a1 - a0) ? 1 : 0;
                exp_q.push_back(e);
                idx++;
            end
        end
    endtask

    task automatic run_sweep(input vec_t v, input string tag);
        int   cyc;
        int   hs;
        bit   got_last;
        bit   rdy;
        exp_t e;
        exp_q.delete();
        build_expect(v.x0, v.x1, v.y0, v.y1, v.serp);
        bus.x0         = 8'(v.x0);
        bus.x1         = 8'(v.x1);
        bus.y0         = 7'(v.y0);
        bus.y1         = 7'(v.y1);
        bus.serpentine = v.serp[0];
        bus.out_ready  = 1'b0;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
        chk({tag, "_latency_valid"}, bus.out_valid, 1);
        cyc      = 0;
        hs       = 0;
        got_last = 0;
        while (cyc < 2000 && !got_last) begin
            rdy = (v.mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            bus.out_ready = rdy;
            chk({tag, "_valid_held"}, bus.out_valid, 1);
            if (exp_q.size() == 0) begin
                chk({tag, "_extra_coord"}, 1, 0);
                got_last = 1;
            end else if (rdy) begin
                e = exp_q.pop_front();
                chk({tag, "_x"}, bus.x, e.x);
                chk({tag, "_y"}, bus.y, e.y);
                chk({tag, "_index"}, bus.index, e.idx);
                chk({tag, "_last"}, bus.last, e.last);
                hs++;
                got_last = (e.last != 0);
            end else begin
                e = exp_q[0];
                chk({tag, "_stall_x"}, bus.x, e.x);
                chk({tag, "_stall_y"}, bus.y, e.y);
                chk({tag, "_stall_index"}, bus.index, e.idx);
            end
            tick();
            cyc++;
        end
        if (!got_last) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_done_pulse"}, bus.done, 1);
            chk({tag, "_valid_after_last"}, bus.out_valid, 0);
            chk({tag, "_busy_after_last"}, bus.busy, 0);
            tick();
            chk({tag, "_done_cleared"}, bus.done, 0);
        end
        chk({tag, "_handshakes"}, hs, v.exp_hs);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
        bus.out_ready = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_bad"}, bus.bad_region, 0);
        chk({tag, "_last"}, bus.last, 0);
        chk({tag, "_x"}, bus.x, 0);
        chk({tag, "_y"}, bus.y, 0);
        chk({tag, "_index"}, bus.index, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        summary();
        $finish;
    end

    initial begin
        vec_t vecs[6];
        vec_t v;
        int   n;
        n_cmp  = 0;
        n_fail = 0;

        vecs[0] = '{x0: 2, x1: 4,   y0: 5,   y1: 6,   serp: 0, mode: 0, exp_hs: 6};
        vecs[1] = '{x0: 2, x1: 4,   y0: 5,   y1: 6,   serp: 1, mode: 0, exp_hs: 6};
        vecs[2] = '{x0: 0, x1: 1,   y0: 0,   y1: 1,   serp: 0, mode: 1, exp_hs: 4};
        vecs[3] = '{x0: 159, x1: 159, y0: 119, y1: 119, serp: 0, mode: 0, exp_hs: 1};
        vecs[4] = '{x0: 3, x1: 3,   y0: 0,   y1: 4,   serp: 1, mode: 0, exp_hs: 5};
        vecs[5] = '{x0: 0, x1: 159, y0: 7,   y1: 7,   serp: 1, mode: 1, exp_hs: 160};

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.serpentine = 1'b0;
        bus.x0         = '0;
        bus.x1         = '0;
        bus.y0         = '0;
        bus.y1         = '0;
        bus.out_ready  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_values("reset");

        for (int i = 0; i < 6; i++) begin
            run_sweep(vecs[i], $sformatf("vec%0d", i));
        end

        // Illegal region: x1 < x0.
        bus.x0    = 8'd9;
        bus.x1    = 8'd3;
        bus.y0    = 7'd0;
        bus.y1    = 7'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("bad_pulse", bus.bad_region, 1);
        chk("bad_busy", bus.busy, 0);
        chk("bad_valid", bus.out_valid, 0);
        tick();
        chk("bad_pulse_clear", bus.bad_region, 0);
        chk("bad_valid_after", bus.out_valid, 0);
        chk("bad_done", bus.done, 0);

        // Abort at index 37 of a 10x10 raster sweep, with ready high.
        bus.x0         = 8'd0;
        bus.x1         = 8'd9;
        bus.y0         = 7'd0;
        bus.y1         = 7'd9;
        bus.serpentine = 1'b0;
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.index != 15'd37 && n < 200) begin
            tick();
            n++;
        end
        chk("abort_reached_37", n, 37);
        chk("abort_x", bus.x, 7);
        chk("abort_y", bus.y, 3);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        tick();
        chk("abort_done_later", bus.done, 0);
        v = '{x0: 0, x1: 9, y0: 0, y1: 9, serp: 0, mode: 0, exp_hs: 100};
        run_sweep(v, "after_abort");

        // Reset asserted in the middle of a serpentine sweep.
        bus.x0         = 8'd3;
        bus.x1         = 8'd8;
        bus.y0         = 7'd2;
        bus.y1         = 7'd6;
        bus.serpentine = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("midreset");
        v = '{x0: 3, x1: 8, y0: 2, y1: 6, serp: 1, mode: 0, exp_hs: 30};
        run_sweep(v, "after_reset");

        // start held high across a whole sweep of (0,0),(1,0).
        bus.x0         = 8'd0;
        bus.x1         = 8'd1;
        bus.y0         = 7'd0;
        bus.y1         = 7'd0;
        bus.serpentine = 1'b0;
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        tick();
        chk("hold_first_x", bus.x, 0);
        chk("hold_first_index", bus.index, 0);
        tick();
        chk("hold_second_x", bus.x, 1);
        chk("hold_second_index", bus.index, 1);
        chk("hold_second_last", bus.last, 1);
        tick();
        chk("hold_done", bus.done, 1);
        chk("hold_done_valid", bus.out_valid, 0);
        tick();
        chk("hold_idle_valid", bus.out_valid, 0);
        chk("hold_idle_busy", bus.busy, 0);
        tick();
        chk("hold_restart_valid", bus.out_valid, 1);
        chk("hold_restart_x", bus.x, 0);
        chk("hold_restart_index", bus.index, 0);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("hold_abort_valid", bus.out_valid, 0);

        summary();
        $finish;
    end

endmodule
